// File: rtl/parity_ctrl_pkg.sv
// Shared types and constants for the parity frame transmit/receive controllers.
package parity_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_acc.sv
// 1-bit registered XOR accumulator; clear has priority over enable.
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ bit_in;
        end
    end

endmodule

// File: rtl/parity_frame_tx.sv
// Serialises words LSB-first over a valid/ready link and appends one parity bit per frame.
module parity_frame_tx
    import parity_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ODD    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_first,
    output logic              ser_last,
    output logic              busy
);

    localparam int unsigned      CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DATA_W - 1);
    localparam logic             PAR_SENSE  = (ODD != 0) ? PAR_ODD : PAR_EVEN;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  cnt;
    logic              acc;
    logic              ready_int;
    logic              accept;
    logic              shift_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accept in PAR with ser_ready jumps straight to DATA for zero-bubble framing.
    always_comb begin
        state_nxt = state;
        ready_int = 1'b0;
        case (state)
            IDLE: begin
                ready_int = 1'b1;
                if (in_valid) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (ser_ready && (cnt == CNT_LAST)) begin
                    state_nxt = PAR;
                end
            end
            PAR: begin
                if (ser_ready) begin
                    ready_int = 1'b1;
                    state_nxt = in_valid ? DATA : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept   = in_valid & ready_int;
    assign shift_en = (state == DATA) & ser_ready;

    // Reset forces IDLE asynchronously; in_ready is masked so it too reads 0 during reset.
    assign in_ready  = ready_int & ~rst;
    assign ser_valid = (state == DATA) | (state == PAR);
    assign busy      = (state != IDLE);
    assign ser_first = (state == DATA) & (cnt == '0);
    assign ser_last  = (state == PAR);
    assign ser_out   = (state == PAR)  ? (acc ^ PAR_SENSE) :
                       (state == DATA) ? shift[0] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shift <= in_data;
            cnt   <= '0;
        end else if (shift_en) begin
            shift <= {1'b0, shift[DATA_W-1:1]};
            if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    parity_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (shift_en),
        .bit_in (shift[0]),
        .acc    (acc)
    );

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: even/odd 8-bit instances in lockstep plus a 2-bit instance.
module tb_parity_frame_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] dat8 = '0;
    logic       vld8 = 1'b0;
    logic       rdy8 = 1'b1;
    logic ir_e, so_e, sv_e, sf_e, sl_e, bz_e;
    logic ir_o, so_o, sv_o, sf_o, sl_o, bz_o;

    logic [1:0] dat2 = '0;
    logic       vld2 = 1'b0;
    logic       rdy2 = 1'b1;
    logic ir_2, so_2, sv_2, sf_2, sl_2, bz_2;

    int errors = 0;
    int checks = 0;

    parity_frame_tx #(.DATA_W(8), .ODD(0)) u_even (
        .clk(clk), .rst(rst), .in_data(dat8), .in_valid(vld8), .in_ready(ir_e),
        .ser_out(so_e), .ser_valid(sv_e), .ser_ready(rdy8), .ser_first(sf_e),
        .ser_last(sl_e), .busy(bz_e)
    );

    parity_frame_tx #(.DATA_W(8), .ODD(1)) u_odd (
        .clk(clk), .rst(rst), .in_data(dat8), .in_valid(vld8), .in_ready(ir_o),
        .ser_out(so_o), .ser_valid(sv_o), .ser_ready(rdy8), .ser_first(sf_o),
        .ser_last(sl_o), .busy(bz_o)
    );

    parity_frame_tx #(.DATA_W(2), .ODD(0)) u_w2 (
        .clk(clk), .rst(rst), .in_data(dat2), .in_valid(vld2), .in_ready(ir_2),
        .ser_out(so_2), .ser_valid(sv_2), .ser_ready(rdy2), .ser_first(sf_2),
        .ser_last(sl_2), .busy(bz_2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " in_ready_e"}, ir_e, 0);
        check({tag, " ser_out_e"}, so_e, 0);
        check({tag, " ser_valid_e"}, sv_e, 0);
        check({tag, " ser_first_e"}, sf_e, 0);
        check({tag, " ser_last_e"}, sl_e, 0);
        check({tag, " busy_e"}, bz_e, 0);
        check({tag, " in_ready_o"}, ir_o, 0);
        check({tag, " ser_valid_o"}, sv_o, 0);
        check({tag, " ser_out_o"}, so_o, 0);
        check({tag, " in_ready_2"}, ir_2, 0);
        check({tag, " ser_valid_2"}, sv_2, 0);
    endtask

    // One 8-bit frame; stall!=0 applies ser_ready pattern 1,0,0,1 repeating.
    task automatic run_frame8(input logic [7:0] w, input logic pe, input logic po,
                              input int stall, input string tag);
        int i = 0;
        int cyc = 0;
        check({tag, " in_ready idle"}, ir_e, 1);
        dat8 = w;
        vld8 = 1'b1;
        rdy8 = 1'b1;
        @(posedge clk); #1;
        vld8 = 1'b0;
        dat8 = w ^ 8'h5A;
        while (i < 9 && cyc < 40) begin
            rdy8 = (stall != 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            @(negedge clk);
            check({tag, " ser_valid"}, sv_e, 1);
            check({tag, " ser_out_even"}, so_e, (i < 8) ? w[i] : pe);
            check({tag, " ser_out_odd"}, so_o, (i < 8) ? w[i] : po);
            check({tag, " ser_first"}, sf_e, (i == 0));
            check({tag, " ser_last"}, sl_e, (i == 8));
            check({tag, " in_ready"}, ir_e, (i == 8) && rdy8);
            if (rdy8) i++;
            cyc++;
            @(posedge clk); #1;
        end
        check({tag, " frame cycles"}, cyc, (stall != 0) ? 17 : 9);
        rdy8 = 1'b1;
        check({tag, " busy after"}, bz_e, 0);
    endtask

    task automatic run_frame2(input logic [1:0] w, input logic par, input string tag);
        logic [2:0] exp;
        exp = {par, w};
        check({tag, " in_ready idle"}, ir_2, 1);
        dat2 = w;
        vld2 = 1'b1;
        @(posedge clk); #1;
        vld2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check({tag, " ser_valid"}, sv_2, 1);
            check({tag, " ser_out"}, so_2, exp[k]);
            check({tag, " ser_first"}, sf_2, (k == 0));
            check({tag, " ser_last"}, sl_2, (k == 2));
            @(posedge clk); #1;
        end
        check({tag, " idle after 3"}, sv_2, 0);
    endtask

    typedef struct {
        logic [7:0] word;
        logic       par_even;
        logic       par_odd;
        int         stall;
    } vec_t;

    typedef struct {
        logic b_e;
        logic b_o;
        logic first;
        logic last;
    } sbit_t;

    initial begin
        vec_t       vecs[$];
        sbit_t      q[$];
        sbit_t      e;
        logic [17:0] b2b_e;
        logic [17:0] b2b_o;
        logic       acc_prev;
        logic       acc_now;
        logic       exp_ir;
        logic       par;

        vecs.push_back('{8'hA5, 1'b0, 1'b1, 0});
        vecs.push_back('{8'h07, 1'b1, 1'b0, 0});
        vecs.push_back('{8'h00, 1'b0, 1'b1, 0});
        vecs.push_back('{8'h3C, 1'b0, 1'b1, 1});
        vecs.push_back('{8'h6E, 1'b1, 1'b0, 1});
        vecs.push_back('{8'h80, 1'b1, 1'b0, 0});

        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset in_ready", ir_e, 1);
        check("post-reset busy", bz_e, 0);

        foreach (vecs[n]) begin
            run_frame8(vecs[n].word, vecs[n].par_even, vecs[n].par_odd, vecs[n].stall,
                       $sformatf("vec%0d", n));
        end

        // Back-to-back: FF then 01 with in_valid held; no gap between frames.
        b2b_e = {1'b1, 8'h01, 1'b0, 8'hFF};
        b2b_o = {1'b0, 8'h01, 1'b1, 8'hFF};
        dat8 = 8'hFF;
        vld8 = 1'b1;
        rdy8 = 1'b1;
        @(posedge clk); #1;
        dat8 = 8'h01;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            check("b2b ser_valid", sv_e, 1);
            check("b2b ser_out_even", so_e, b2b_e[k]);
            check("b2b ser_out_odd", so_o, b2b_o[k]);
            check("b2b ser_first", sf_e, (k == 0) || (k == 9));
            check("b2b ser_last", sl_e, (k == 8) || (k == 17));
            if (k == 8) check("b2b in_ready at parity", ir_e, 1);
            @(posedge clk); #1;
            if (k == 8) vld8 = 1'b0;
        end
        check("b2b busy after", bz_e, 0);

        // Reset mid-frame at data bit 4 of F0.
        dat8 = 8'hF0;
        vld8 = 1'b1;
        @(posedge clk); #1;
        vld8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst bit4 valid", sv_e, 1);
        check("midrst bit4 value", so_e, 1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst release in_ready", ir_e, 1);
        check("midrst release busy", bz_e, 0);
        check("midrst release valid", sv_e, 0);
        run_frame8(8'h81, 1'b0, 1'b1, 0, "post_rst");

        run_frame2(2'b01, 1'b1, "w2_01");
        run_frame2(2'b11, 1'b0, "w2_11");

        // Random traffic against a frame-level scoreboard.
        acc_prev = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!vld8 || acc_prev) begin
                vld8 = ($urandom % 3) != 0;
                dat8 = 8'($urandom);
            end
            rdy8 = ($urandom % 4) != 0;
            if (c >= 1480) begin
                vld8 = 1'b0;
                rdy8 = 1'b1;
            end
            @(negedge clk);
            exp_ir = (q.size() == 0) || ((q.size() == 1) && rdy8);
            check("rand ser_valid", sv_e, (q.size() > 0));
            check("rand in_ready", ir_e, exp_ir);
            check("rand odd in_ready", ir_o, exp_ir);
            acc_now = vld8 && ir_e;
            if (sv_e && rdy8) begin
                if (q.size() == 0) begin
                    check("rand spurious transfer", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("rand ser_out_even", so_e, e.b_e);
                    check("rand ser_out_odd", so_o, e.b_o);
                    check("rand ser_first", sf_e, e.first);
                    check("rand ser_last", sl_e, e.last);
                end
            end
            if (acc_now) begin
                for (int b = 0; b < 8; b++) begin
                    q.push_back('{dat8[b], dat8[b], (b == 0), 1'b0});
                end
                par = ($countones(dat8) % 2) != 0;
                q.push_back('{par, ~par, 1'b0, 1'b1});
            end
            acc_prev = acc_now;
            @(posedge clk); #1;
        end
        check("rand drained", q.size(), 0);
        check("rand idle at end", bz_e, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
